pll_clk_supervisor: RTL and testbench

Parametrised clock supervisor that sits directly behind the Gowin rPLL, clocked by the PLL output (e.g. 108 MHz from a 27 MHz input). It qualifies the raw PLL LOCK signal and sequences a synchronous system reset for downstream logic. It also produces NUM_CH independent fractional clock-enable tick streams (Z80 CPU, audio, UART, video) from runtime-programmable phase-accumulator increments. It replaces ad-hoc per-module dividers and the unused LOCK output of the plain PLL wrapper.

---
 rtl/pll_clk_supervisor.sv | 139 +++++++++++++
 tb/tb_pll_clk_supervisor.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_clk_supervisor.sv
// PLL clock supervisor: qualifies the rPLL LOCK signal, sequences a
// synchronous downstream reset and generates NUM_CH fractional
// clock-enable tick streams from programmable phase increments.
module pll_clk_supervisor #(
  parameter int               NUM_CH      = 4,
  parameter int               ACC_W       = 24,
  parameter logic [ACC_W-1:0] INC_DEFAULT = '0,
  parameter int               LOCK_STABLE = 1024,
  parameter int               RST_HOLD    = 16,
  parameter int               SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pll_lock,
  input  logic [NUM_CH*ACC_W-1:0] inc_in,
  input  logic                    inc_load,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic                    clr_status,
  output logic [NUM_CH-1:0]       tick,
  output logic                    locked,
  output logic                    sys_reset,
  output logic                    lock_lost,
  output logic [1:0]              state
);

  localparam int CNT_MAX = (LOCK_STABLE > RST_HOLD) ? LOCK_STABLE : RST_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD - 1);

  typedef enum logic [1:0] {
    S_WAIT    = 2'd0,
    S_STABLE  = 2'd1,
    S_RELEASE = 2'd2,
    S_RUN     = 2'd3
  } state_t;

  state_t                 st;
  logic [CNT_W-1:0]       cnt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic                   run_ok;

  assign lock_s = sync_q[SYNC_STAGES-1];
  assign state  = st;
  // Accumulators stop on the very cycle a loss is detected, so no tick
  // escapes while the FSM is leaving RUN.
  assign run_ok = (st == S_RUN) && lock_s;

  // Bring the asynchronous LOCK into the clk domain; cleared by reset so
  // qualification always restarts from scratch.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
  end

  // Lock qualification / reset sequencing FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= S_WAIT;
      cnt       <= '0;
      locked    <= 1'b0;
      sys_reset <= 1'b1;
      lock_lost <= 1'b0;
    end else begin
      if (clr_status) lock_lost <= 1'b0;
      case (st)
        S_WAIT: begin
          cnt <= '0;
          if (lock_s) st <= S_STABLE;
        end
        S_STABLE: begin
          if (!lock_s) begin
            st  <= S_WAIT;
            cnt <= '0;
          end else if (cnt == STABLE_LAST) begin
            st        <= S_RELEASE;
            cnt       <= '0;
            locked    <= 1'b1;
            sys_reset <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RELEASE, S_RUN: begin
          if (!lock_s) begin
            // Loss set wins over a simultaneous clr_status.
            st        <= S_WAIT;
            cnt       <= '0;
            locked    <= 1'b0;
            sys_reset <= 1'b1;
            lock_lost <= 1'b1;
          end else if (st == S_RELEASE) begin
            if (cnt == HOLD_LAST) begin
              st        <= S_RUN;
              sys_reset <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          st        <= S_WAIT;
          cnt       <= '0;
          locked    <= 1'b0;
          sys_reset <= 1'b1;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [ACC_W-1:0] shadow_q;
    logic [ACC_W-1:0] acc_q;
    logic             tick_q;
    logic [ACC_W:0]   sum;

    assign sum     = {1'b0, acc_q} + {1'b0, shadow_q};
    assign tick[g] = tick_q;

    // Increment shadow; reloading does not touch the accumulator phase.
    always_ff @(posedge clk) begin
      if (reset)         shadow_q <= INC_DEFAULT;
      else if (inc_load) shadow_q <= inc_in[g*ACC_W +: ACC_W];
    end

    // Phase accumulator; the carry out becomes next cycle's tick.
    always_ff @(posedge clk) begin
      if (reset || !run_ok || !ch_en[g]) begin
        acc_q  <= '0;
        tick_q <= 1'b0;
      end else begin
        acc_q  <= sum[ACC_W-1:0];
        tick_q <= sum[ACC_W];
      end
    end
  end

endmodule

// File: tb/tb_pll_clk_supervisor.sv
// Self-checking bench for pll_clk_supervisor (ACC_W=8, LOCK_STABLE=16,
// RST_HOLD=4). Tick expectations come from an unbounded-phase model.
module tb_pll_clk_supervisor;
  localparam int NCH = 4;
  localparam int AW  = 8;
  localparam int LS  = 16;
  localparam int RH  = 4;
  localparam int SS  = 2;

  logic              clk = 1'b0;
  logic              reset, pll_lock, inc_load, clr_status;
  logic [NCH*AW-1:0] inc_in;
  logic [NCH-1:0]    ch_en;
  logic [NCH-1:0]    tick;
  logic              locked, sys_reset, lock_lost;
  logic [1:0]        state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // model: unbounded phase per channel, active shadow, run flag
  longint ph[NCH];
  int     sh[NCH];
  bit     run_m = 0;

  pll_clk_supervisor #(
    .NUM_CH(NCH), .ACC_W(AW), .INC_DEFAULT(8'd0),
    .LOCK_STABLE(LS), .RST_HOLD(RH), .SYNC_STAGES(SS)
  ) dut (
    .clk(clk), .reset(reset), .pll_lock(pll_lock), .inc_in(inc_in),
    .inc_load(inc_load), .ch_en(ch_en), .clr_status(clr_status),
    .tick(tick), .locked(locked), .sys_reset(sys_reset),
    .lock_lost(lock_lost), .state(state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // one clock with model update and tick comparison
  task automatic mstep();
    logic [NCH-1:0]    en, exp;
    logic              ld;
    logic [NCH*AW-1:0] li;
    longint            old;
    en = ch_en; ld = inc_load; li = inc_in;
    step();
    for (int i = 0; i < NCH; i++) begin
      if (run_m && en[i]) begin
        old    = ph[i];
        ph[i]  = ph[i] + sh[i];
        exp[i] = (ph[i] / 256) != (old / 256);
      end else begin
        ph[i]  = 0;
        exp[i] = 1'b0;
      end
    end
    if (ld) for (int i = 0; i < NCH; i++) sh[i] = int'(li[i*AW +: AW]);
    checks++;
    if (tick !== exp) begin
      errors++;
      $display("FAIL tick_model cyc=%0d: got %b expected %b", cyc, tick, exp);
    end
  endtask

  task automatic model_clear();
    run_m = 0;
    for (int i = 0; i < NCH; i++) ph[i] = 0;
  endtask

  // Wait for qualification after a pll_lock rise; checks lock latency,
  // reset hold length and state order, then arms the tick model.
  task automatic wait_run(input string nm, input int lo, input int hi);
    int         n;
    logic [1:0] seq[$];
    logic [1:0] last;
    model_clear();
    last = state;
    seq.push_back(state);
    n = 0;
    while (locked !== 1'b1 && n < 200) begin
      mstep(); n++;
      if (state !== last) begin last = state; seq.push_back(state); end
    end
    checks++;
    if (n < lo || n > hi) begin
      errors++;
      $display("FAIL %s_lock_latency: got %0d cycles expected %0d..%0d", nm, n, lo, hi);
    end
    n = 0;
    while (sys_reset !== 1'b0 && n < 50) begin
      mstep(); n++;
      if (state !== last) begin last = state; seq.push_back(state); end
    end
    checks++;
    if (n != RH) begin
      errors++;
      $display("FAIL %s_reset_hold: got %0d cycles expected %0d", nm, n, RH);
    end
    checks++;
    if (seq.size() != 4 || seq[0] !== 2'd0 || seq[1] !== 2'd1 || seq[2] !== 2'd2 || seq[3] !== 2'd3) begin
      errors++;
      $display("FAIL %s_state_seq: got %p expected 0,1,2,3", nm, seq);
    end
    run_m = 1;
  endtask

  task automatic test_reset();
    reset = 1; pll_lock = 0; inc_load = 0; clr_status = 0; inc_in = '0; ch_en = '0;
    step(); step();
    checks++;
    if ({state, locked, sys_reset, lock_lost, tick} !== {2'd0, 1'b0, 1'b1, 1'b0, 4'b0}) begin
      errors++;
      $display("FAIL reset_state: got st=%0d lk=%b sr=%b ll=%b tk=%b expected 0 0 1 0 0000",
               state, locked, sys_reset, lock_lost, tick);
    end
    reset = 0;
    cyc = 0;
    for (int i = 0; i < NCH; i++) sh[i] = 0;
    model_clear();
  endtask

  task automatic test_lock_seq();
    inc_in = {8'd0, 8'd255, 8'd128, 8'd64};
    inc_load = 1; mstep(); inc_load = 0;
    ch_en = 4'hF;
    while (cyc < 10) mstep();
    checks++;
    if (state !== 2'd0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL idle_wait: got st=%0d lk=%b expected 0 0", state, locked);
    end
    pll_lock = 1;
    wait_run("lock_seq", LS + SS, LS + SS + 1);
  endtask

  task automatic test_ticks();
    int             cnt[NCH];
    int             last0;
    bit             gap_ok, single_ok;
    logic [NCH-1:0] prev;
    for (int i = 0; i < NCH; i++) cnt[i] = 0;
    last0 = -1; gap_ok = 1; single_ok = 1; prev = '0;
    for (int k = 0; k < 256; k++) begin
      mstep();
      for (int i = 0; i < NCH; i++) if (tick[i]) cnt[i]++;
      if (tick[0]) begin
        if (last0 >= 0 && k - last0 != 4) gap_ok = 0;
        last0 = k;
      end
      if ((tick[0] && prev[0]) || (tick[1] && prev[1])) single_ok = 0;
      prev = tick;
    end
    checks++; if (cnt[0] != 64)  begin errors++; $display("FAIL ticks_ch0: got %0d expected 64", cnt[0]); end
    checks++; if (cnt[1] != 128) begin errors++; $display("FAIL ticks_ch1: got %0d expected 128", cnt[1]); end
    checks++; if (cnt[2] != 255) begin errors++; $display("FAIL ticks_ch2: got %0d expected 255", cnt[2]); end
    checks++; if (cnt[3] != 0)   begin errors++; $display("FAIL ticks_ch3: got %0d expected 0", cnt[3]); end
    checks++; if (!gap_ok)    begin errors++; $display("FAIL ch0_period: got irregular expected every 4"); end
    checks++; if (!single_ok) begin errors++; $display("FAIL single_cycle: got stretched tick expected 1-cycle"); end
  endtask

  task automatic test_inc_load();
    int n;
    int hits[$];
    n = 0;
    while ((ph[0] % 256) != 128 && n < 8) begin mstep(); n++; end
    inc_in[7:0] = 8'd32;
    inc_load = 1; mstep(); inc_load = 0;   // this accumulate still adds 64 -> 192
    for (int k = 1; k <= 20; k++) begin
      mstep();
      if (tick[0]) hits.push_back(k);
    end
    checks++;
    if (hits.size() < 3 || hits[0] != 2 || hits[1] != 10 || hits[2] != 18) begin
      errors++;
      $display("FAIL inc_load_phase: got %p expected 2,10,18", hits);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(15) == 0) ch_en[$urandom_range(NCH-1)] ^= 1'b1;
      if ($urandom_range(31) == 0) begin inc_in = $urandom; inc_load = 1; end
      mstep();
      inc_load = 0;
    end
    ch_en = 4'hF;
  endtask

  task automatic test_lock_loss();
    pll_lock = 0;
    step(); step();
    checks++;
    if (locked !== 1'b1) begin
      errors++; $display("FAIL loss_sync_delay: got locked=%b expected 1", locked);
    end
    step();
    checks++;
    if ({tick, locked, sys_reset, lock_lost, state} !== {4'b0, 1'b0, 1'b1, 1'b1, 2'd0}) begin
      errors++;
      $display("FAIL loss_outputs: got tk=%b lk=%b sr=%b ll=%b st=%0d expected 0000 0 1 1 0",
               tick, locked, sys_reset, lock_lost, state);
    end
    model_clear();
    clr_status = 1; mstep(); clr_status = 0;
    checks++;
    if (lock_lost !== 1'b0) begin errors++; $display("FAIL clr_alone: got %b expected 0", lock_lost); end
    pll_lock = 1;
    wait_run("relock", LS + SS, LS + SS + 1);
    pll_lock = 0;
    step(); step();
    clr_status = 1; step(); clr_status = 0;
    checks++;
    if (lock_lost !== 1'b1 || state !== 2'd0) begin
      errors++; $display("FAIL set_over_clr: got ll=%b st=%0d expected 1 0", lock_lost, state);
    end
    model_clear();
    clr_status = 1; mstep(); clr_status = 0;
    checks++;
    if (lock_lost !== 1'b0) begin errors++; $display("FAIL clr_after_set: got %b expected 0", lock_lost); end
  endtask

  task automatic test_glitch();
    pll_lock = 1;
    for (int k = 0; k < 11; k++) mstep();
    checks++;
    if (state !== 2'd1) begin errors++; $display("FAIL glitch_in_stable: got st=%0d expected 1", state); end
    pll_lock = 0;
    for (int k = 0; k < 3; k++) mstep();
    checks++;
    if (state !== 2'd0 || locked !== 1'b0) begin
      errors++; $display("FAIL glitch_back_wait: got st=%0d lk=%b expected 0 0", state, locked);
    end
    pll_lock = 1;
    wait_run("glitch", LS + SS, LS + SS + 1);
    checks++;
    if (lock_lost !== 1'b0) begin errors++; $display("FAIL glitch_no_flag: got %b expected 0", lock_lost); end
  endtask

  task automatic test_reset_mid_run();
    int i0, n;
    for (int k = 0; k < 10; k++) mstep();
    reset = 1; step(); reset = 0;
    for (int i = 0; i < NCH; i++) sh[i] = 0;
    model_clear();
    checks++;
    if ({state, locked, sys_reset, lock_lost, tick} !== {2'd0, 1'b0, 1'b1, 1'b0, 4'b0}) begin
      errors++;
      $display("FAIL midrun_reset: got st=%0d lk=%b sr=%b ll=%b tk=%b expected 0 0 1 0 0000",
               state, locked, sys_reset, lock_lost, tick);
    end
    wait_run("post_reset", LS + SS, LS + SS + 1);
    i0 = $urandom_range(255, 1);
    inc_in = $urandom;
    inc_in[7:0] = 8'(i0);
    inc_load = 1; mstep(); inc_load = 0;
    for (int k = 0; k < 30; k++) mstep();
    ch_en[0] = 0;
    for (int k = 0; k < 5; k++) mstep();
    ch_en[0] = 1;
    n = 0;
    do begin mstep(); n++; end while (tick[0] !== 1'b1 && n < 300);
    checks++;
    if (n != (256 + i0 - 1) / i0) begin
      errors++; $display("FAIL reenable_phase: got %0d accumulates expected %0d (inc=%0d)", n, (256 + i0 - 1) / i0, i0);
    end
  endtask

  initial begin
    test_reset();
    test_lock_seq();
    test_ticks();
    test_inc_load();
    test_random();
    test_lock_loss();
    test_glitch();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
